// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, N iterations per op.
// Returns product[N-1:0] with C/V/Z flags matching the combinational multiply.
module mult_seq_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         flagC,
  output logic         flagV,
  output logic         flagZ
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q;
  logic            b_msb_q;
  logic [2*N-1:0]  p_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    result_q;
  logic            flag_c_q, flag_v_q, flag_z_q;

  logic            accept_c;
  logic            iter_c;
  logic            last_iter_c;
  logic [N:0]      sum_c;
  logic [2*N-1:0]  p_step_c;

  assign accept_c    = (state_q == IDLE) && start && !abort;
  assign iter_c      = (state_q == RUN) && !abort;
  assign last_iter_c = iter_c && (cnt_q == CW'(N - 1));

  // One iteration: conditional add into the upper half, then shift {carry, P} right.
  always_comb begin
    sum_c    = {1'b0, p_q[2*N-1:N]};
    p_step_c = p_q;
    if (p_q[0]) begin
      sum_c = {1'b0, p_q[2*N-1:N]} + {1'b0, a_q};
    end
    p_step_c = {sum_c, p_q[N-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_iter_c) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Result/flags update only on the final iteration, so partial products never appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_msb_q  <= 1'b0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (accept_c) begin
      a_q     <= a;
      b_msb_q <= b[N-1];
      p_q     <= {N'(0), b};
      cnt_q   <= '0;
    end else if (iter_c) begin
      p_q   <= p_step_c;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter_c) begin
        result_q <= p_step_c[N-1:0];
        flag_c_q <= p_step_c[N];
        flag_z_q <= (p_step_c[N-1:0] == '0);
        flag_v_q <= (a_q[N-1] & b_msb_q & ~p_step_c[N-1]) |
                    (~a_q[N-1] & ~b_msb_q & p_step_c[N-1]);
      end
    end
  end

  assign result = result_q;
  assign flagC  = flag_c_q;
  assign flagV  = flag_v_q;
  assign flagZ  = flag_z_q;

endmodule
